pixel_compositor: RTL and testbench

Pipelined final pixel stage between the sprite/background generators and the VGA DAC pins. Each cycle it takes the per-layer hit flags and RGB values for the current DrawX/DrawY, resolves priority and chroma-key transparency, and selects background, end-zone tint or start screen. It applies a frame-stepped fade-in when play begins and drives registered 8-bit Red/Green/Blue with blanking enforced.

---
 rtl/pixel_compositor.sv | 160 ++++++++++++++++
 tb/tb_pixel_compositor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// Final pixel stage: layer priority with chroma key, end-zone/start-screen select, fade-in, blanking.
// Define PIXEL_COMPOSITOR_FADE_EN to build the START/FADE/PLAY fade-in FSM and channel multiplier.
module pixel_compositor #(
  parameter int unsigned NUM_LAYERS  = 8,
  parameter logic [23:0] KEY_COLOR   = 24'hFF0000,
  parameter int unsigned END_STEP    = 400,
  parameter logic [23:0] END_COLOR   = 24'hFF69B4,
  parameter int unsigned FADE_FRAMES = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic                     blank,
  input  logic                     game_on,
  input  logic [8:0]               bg_step,
  input  logic [NUM_LAYERS-1:0]    layer_hit,
  input  logic [24*NUM_LAYERS-1:0] layer_rgb,
  input  logic [23:0]              bg_rgb,
  input  logic [23:0]              start_rgb,
  output logic [7:0]               Red,
  output logic [7:0]               Green,
  output logic [7:0]               Blue,
  output logic                     pix_valid
);

  logic [23:0]      sel_rgb;
  logic             end_zone;
  logic [23:0]      s1_rgb_q;
  logic             s1_blank_q;
  logic [2:0][7:0]  pix_in, pix_out;
  logic [23:0]      out_q;
  logic             valid_q;

  assign end_zone = 32'(bg_step) > END_STEP;

  // Walk from lowest priority upward so the last match is the lowest index.
  always_comb begin
    sel_rgb = end_zone ? END_COLOR : bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && (layer_rgb[24*i +: 24] != KEY_COLOR)) begin
        sel_rgb = layer_rgb[24*i +: 24];
      end
    end
    if (!game_on) begin
      sel_rgb = start_rgb;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_rgb_q   <= '0;
      s1_blank_q <= 1'b0;
    end else begin
      s1_rgb_q   <= sel_rgb;
      s1_blank_q <= blank;
    end
  end

  assign pix_in = s1_rgb_q;

`ifdef PIXEL_COMPOSITOR_FADE_EN
  localparam int unsigned LvlW  = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int unsigned Shift = $clog2(FADE_FRAMES);

  typedef enum logic [1:0] {StStart, StFade, StPlay} state_e;

  state_e            state_q, state_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              fclk_q;
  logic              tick;
  logic [LvlW:0]     mult;
  logic [8+LvlW:0]   prod;

  assign tick = frame_clk & ~fclk_q;
  assign mult = {1'b0, level_q} + (LvlW+1)'(1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StStart: begin
        level_d = '0;
        if (game_on) state_d = StFade;
      end
      StFade: begin
        // A falling game_on takes precedence over a coincident tick.
        if (!game_on) begin
          state_d = StStart;
          level_d = '0;
        end else if (tick) begin
          if (level_q == LvlW'(FADE_FRAMES - 1)) state_d = StPlay;
          else level_d = level_q + LvlW'(1);
        end
      end
      StPlay: begin
        if (!game_on) begin
          state_d = StStart;
          level_d = '0;
        end
      end
      default: begin
        state_d = StStart;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StStart;
      level_q <= '0;
      fclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fclk_q  <= frame_clk;
    end
  end

  always_comb begin
    pix_out = pix_in;
    prod    = '0;
    if (state_q == StFade) begin
      for (int c = 0; c < 3; c++) begin
        prod       = (9+LvlW)'(pix_in[c]) * (9+LvlW)'(mult);
        pix_out[c] = prod[Shift +: 8];
      end
    end
    if (!s1_blank_q) begin
      pix_out = '0;
    end
  end
`else
  logic unused_fade;
  assign unused_fade = frame_clk | (FADE_FRAMES == 0);

  always_comb begin
    pix_out = pix_in;
    if (!s1_blank_q) begin
      pix_out = '0;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= pix_out;
      valid_q <= s1_blank_q;
    end
  end

  assign Red       = out_q[23:16];
  assign Green     = out_q[15:8];
  assign Blue      = out_q[7:0];
  assign pix_valid = valid_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: directed table, fade/reset sequences, random vs model.
module tb_pixel_compositor;
  localparam int NL = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           frame_clk = 1'b0;
  logic           blank = 1'b0;
  logic           game_on = 1'b0;
  logic [8:0]     bg_step = '0;
  logic [NL-1:0]  layer_hit = '0;
  logic [NL*24-1:0] layer_rgb = '0;
  logic [23:0]    bg_rgb = '0;
  logic [23:0]    start_rgb = '0;
  logic [7:0]     Red, Green, Blue;
  logic           pix_valid;

`ifdef PIXEL_COMPOSITOR_FADE_EN
  localparam bit FadeEn = 1'b1;
`else
  localparam bit FadeEn = 1'b0;
`endif

  pixel_compositor dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .blank     (blank),
    .game_on   (game_on),
    .bg_step   (bg_step),
    .layer_hit (layer_hit),
    .layer_rgb (layer_rgb),
    .bg_rgb    (bg_rgb),
    .start_rgb (start_rgb),
    .Red       (Red),
    .Green     (Green),
    .Blue      (Blue),
    .pix_valid (pix_valid)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [NL-1:0]    hit;
    logic [NL*24-1:0] lr;
    logic [23:0]      bg;
    logic [8:0]       stp;
    logic [23:0]      start;
    logic             on;
    logic             blk;
    logic [24:0]      exp;
  } vec_t;

  vec_t tv[8];
  logic [24:0] exp_q[$];

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] got;
    got = {pix_valid, Red, Green, Blue};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got valid=%0b rgb=%06h, expected valid=%0b rgb=%06h",
               name, got[24], got[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    step(2);
    frame_clk = 1'b0;
    step(2);
  endtask

  // Reference: first visible hit in priority order, else end zone / background.
  function automatic logic [23:0] ref_pix(input logic [NL-1:0] hit, input logic [NL*24-1:0] lr,
                                          input logic [23:0] bg, input logic [8:0] stp,
                                          input logic [23:0] start, input logic on);
    if (!on) return start;
    for (int i = 0; i < NL; i++) begin
      if (hit[i] && lr[i*24 +: 24] != 24'hFF0000) return lr[i*24 +: 24];
    end
    if (int'(stp) > 400) return 24'hFF69B4;
    return bg;
  endfunction

  function automatic logic [23:0] fade(input logic [23:0] c, input int lvl);
    int r, g, b;
    if (!FadeEn) return c;
    r = (int'(c[23:16]) * (lvl + 1)) / 16;
    g = (int'(c[15:8]) * (lvl + 1)) / 16;
    b = (int'(c[7:0]) * (lvl + 1)) / 16;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  initial begin
    // Directed table (applied while in PLAY; game_on=0 entries last).
    foreach (tv[k]) begin
      tv[k].hit = '0; tv[k].lr = '0; tv[k].bg = 24'h00A0FF; tv[k].stp = 9'd0;
      tv[k].start = 24'h000000; tv[k].on = 1'b1; tv[k].blk = 1'b1;
    end
    tv[0].hit = 8'b0000_1001; tv[0].lr[0 +: 24] = 24'hFF0000; tv[0].lr[72 +: 24] = 24'h123456;
    tv[0].bg = 24'h000000; tv[0].exp = {1'b1, 24'h123456};
    tv[1].stp = 9'd400; tv[1].exp = {1'b1, 24'h00A0FF};
    tv[2].stp = 9'd401; tv[2].exp = {1'b1, 24'hFF69B4};
    tv[3].hit = 8'b0000_0001; tv[3].lr[0 +: 24] = 24'hFF0000; tv[3].exp = {1'b1, 24'h00A0FF};
    tv[4].hit = 8'b1000_0000; tv[4].lr[168 +: 24] = 24'h0A0B0C; tv[4].stp = 9'd450;
    tv[4].exp = {1'b1, 24'h0A0B0C};
    tv[5].hit = 8'b1111_1111;
    for (int j = 0; j < NL; j++) tv[5].lr[j*24 +: 24] = 24'h101010 * (j + 1);
    tv[5].lr[0 +: 24] = 24'hFF0000; tv[5].lr[24 +: 24] = 24'hFF0000;
    tv[5].lr[48 +: 24] = 24'h334455; tv[5].exp = {1'b1, 24'h334455};
    tv[6].on = 1'b0; tv[6].start = 24'hABCDEF; tv[6].hit = 8'b0000_0001;
    tv[6].lr[0 +: 24] = 24'h111111; tv[6].exp = {1'b1, 24'hABCDEF};
    tv[7] = tv[6]; tv[7].blk = 1'b0; tv[7].exp = {1'b0, 24'h000000};

    // Reset state
    step(2);
    check("reset", 25'h0);
    Reset = 1'b0;
    step(1);

    // Fade-in from START
    game_on = 1'b1; blank = 1'b1; bg_rgb = 24'hFFFFFF; layer_hit = '0; bg_step = 9'd0;
    step(3);
    check("fade_l0", {1'b1, fade(24'hFFFFFF, 0)});
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 1) check("fade_l1", {1'b1, fade(24'hFFFFFF, 1)});
      if (t == 8) check("fade_l8", {1'b1, fade(24'hFFFFFF, 8)});
    end
    check("play", {1'b1, 24'hFFFFFF});

    // Random traffic in PLAY against the reference model
    for (int i = 0; i < 202; i++) begin
      if (i >= 2) check("random", exp_q.pop_front());
      if (i < 200) begin
        layer_hit = 8'($urandom & $urandom);
        for (int j = 0; j < NL; j++)
          layer_rgb[j*24 +: 24] = ($urandom_range(0, 2) == 0) ? 24'hFF0000 : 24'($urandom);
        bg_rgb    = 24'($urandom);
        bg_step   = 9'($urandom_range(390, 411));
        start_rgb = 24'($urandom);
        blank     = ($urandom_range(0, 7) != 0);
        exp_q.push_back({blank, blank ? ref_pix(layer_hit, layer_rgb, bg_rgb, bg_step,
                                                start_rgb, game_on) : 24'h0});
      end
      step(1);
    end

    // Table
    foreach (tv[k]) begin
      layer_hit = tv[k].hit; layer_rgb = tv[k].lr; bg_rgb = tv[k].bg; bg_step = tv[k].stp;
      start_rgb = tv[k].start; game_on = tv[k].on; blank = tv[k].blk;
      step(2);
      check($sformatf("vec%0d", k), tv[k].exp);
    end

    // Mid-fade drop returns to START with level cleared
    game_on = 1'b1; blank = 1'b1; layer_hit = '0; bg_rgb = 24'hFFFFFF; bg_step = 9'd0;
    start_rgb = 24'h808080;
    step(3);
    tick();
    tick();
    check("fade_l2", {1'b1, fade(24'hFFFFFF, 2)});
    game_on = 1'b0;
    step(3);
    check("drop_start", {1'b1, 24'h808080});
    game_on = 1'b1;
    step(3);
    check("restart_l0", {1'b1, fade(24'hFFFFFF, 0)});

    // Tick coinciding with game_on fall: the fall wins
    tick();
    check("tie_pre_l1", {1'b1, fade(24'hFFFFFF, 1)});
    frame_clk = 1'b1; game_on = 1'b0;
    step(1);
    game_on = 1'b1;
    step(3);
    check("tie_l0", {1'b1, fade(24'hFFFFFF, 0)});
    frame_clk = 1'b0;
    step(2);

    // Reset during active video
    game_on = 1'b0; start_rgb = 24'hABCDEF; blank = 1'b1;
    step(3);
    check("pre_reset", {1'b1, 24'hABCDEF});
    Reset = 1'b1;
    #1;
    check("reset_async", 25'h0);
    step(1);
    Reset = 1'b0;
    step(1);
    check("post_reset_c1", 25'h0);
    step(1);
    check("post_reset_c2", {1'b1, 24'hABCDEF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
